// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller: single-cycle 33x33 multiply and
// restoring radix-2 divide, with a pipeline stall and a one-cycle done pulse.
module muldiv_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4:0]            op_sel,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   output logic                  busy,
   output logic                  stall,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam logic [4:0] OP_MUL    = 5'b01010;
   localparam logic [4:0] OP_MULH   = 5'b01011;
   localparam logic [4:0] OP_MULHSU = 5'b01100;
   localparam logic [4:0] OP_MULHU  = 5'b01101;
   localparam logic [4:0] OP_DIV    = 5'b01110;
   localparam logic [4:0] OP_REM    = 5'b10000;
   localparam logic [4:0] OP_REMU   = 5'b10001;

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   state_t       state_r;
   logic [4:0]   op_r;
   logic [4:0]   cnt_r;
   logic [31:0]  op1_r, op2_r, dvd_r, dvs_r, rem_r, result_r;
   logic         neg_q_r, neg_r_r, busy_r, done_r;

   logic         valid_op_s, accept_s, acc_sgn_s;
   logic         sgn_a_s, sgn_b_s, div_sgn_s, is_rem_s, div_zero_s, div_ovf_s, qbit_s;
   logic signed [32:0] mul_a_s, mul_b_s;
   logic signed [63:0] prod_s;
   logic [31:0]  mul_res_s, rem_nxt_s, quo_nxt_s, div_res_s, special_res_s;
   logic [32:0]  shift_s, diff_s;

   function automatic logic [31:0] abs_val(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (32'd0 - v) : v;
   endfunction

   // Request decode, multiplier datapath and one restoring-division step
   always_comb begin
      valid_op_s = (op_sel >= OP_MUL) && (op_sel <= OP_REMU);
      accept_s   = (state_r == IDLE) && start && valid_op_s;
      acc_sgn_s  = (op_sel == OP_DIV) || (op_sel == OP_REM);

      sgn_a_s   = (op_r == OP_MUL) || (op_r == OP_MULH) || (op_r == OP_MULHSU);
      sgn_b_s   = (op_r == OP_MUL) || (op_r == OP_MULH);
      mul_a_s   = $signed({sgn_a_s & op1_r[31], op1_r});
      mul_b_s   = $signed({sgn_b_s & op2_r[31], op2_r});
      prod_s    = 64'(mul_a_s) * 64'(mul_b_s);
      mul_res_s = (op_r == OP_MUL) ? prod_s[31:0] : prod_s[63:32];

      shift_s   = {rem_r, dvd_r[31]};
      diff_s    = shift_s - {1'b0, dvs_r};
      qbit_s    = ~diff_s[32];
      rem_nxt_s = qbit_s ? diff_s[31:0] : shift_s[31:0];
      quo_nxt_s = {dvd_r[30:0], qbit_s};

      div_sgn_s  = (op_r == OP_DIV) || (op_r == OP_REM);
      is_rem_s   = (op_r == OP_REM) || (op_r == OP_REMU);
      div_zero_s = (op2_r == 32'd0);
      div_ovf_s  = div_sgn_s && (op1_r == 32'h8000_0000) && (op2_r == 32'hFFFF_FFFF);
      div_res_s  = is_rem_s ? cond_neg(rem_nxt_s, neg_r_r) : cond_neg(quo_nxt_s, neg_q_r);
      special_res_s = div_zero_s ? (is_rem_s ? op1_r : 32'hFFFF_FFFF)
                                 : (is_rem_s ? 32'd0 : 32'h8000_0000);
   end

   // Sequencer FSM with registered busy/done/result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         op_r     <= 5'd0;
         cnt_r    <= 5'd0;
         op1_r    <= 32'd0;
         op2_r    <= 32'd0;
         dvd_r    <= 32'd0;
         dvs_r    <= 32'd0;
         rem_r    <= 32'd0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         result_r <= 32'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (accept_s) begin
                  op_r    <= op_sel;
                  op1_r   <= op1;
                  op2_r   <= op2;
                  dvd_r   <= abs_val(op1, acc_sgn_s);
                  dvs_r   <= abs_val(op2, acc_sgn_s);
                  rem_r   <= 32'd0;
                  cnt_r   <= 5'd0;
                  neg_q_r <= acc_sgn_s & (op1[31] ^ op2[31]);
                  neg_r_r <= acc_sgn_s & op1[31];
                  busy_r  <= 1'b1;
                  state_r <= (op_sel <= OP_MULHU) ? MUL : DIV;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            MUL: begin
               result_r <= mul_res_s;
               busy_r   <= 1'b0;
               done_r   <= 1'b1;
               state_r  <= DONE;
            end
            DIV: begin
               // Zero divisor and signed overflow bypass the iterations entirely
               if (div_zero_s || div_ovf_s) begin
                  result_r <= special_res_s;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  dvd_r <= quo_nxt_s;
                  rem_r <= rem_nxt_s;
                  cnt_r <= cnt_r + 5'd1;
                  if (cnt_r == 5'd31) begin
                     result_r <= div_res_s;
                     busy_r   <= 1'b0;
                     done_r   <= 1'b1;
                     state_r  <= DONE;
                  end else begin
                     state_r  <= DIV;
                  end
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;
   assign stall  = busy_r | accept_s;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed operations push expectations,
// a negedge monitor pops and checks result and latency on every done pulse.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [4:0]  op_sel;
   logic [31:0] op1, op2;
   logic        busy, stall, done;
   logic [31:0] result;

   typedef struct {
      string       name;
      logic [31:0] res;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_res = 32'd0;

   muldiv_ctrl #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .op1(op1), .op2(op2),
      .busy(busy), .stall(stall), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 result=%h expected no pending operation", result);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
            last_res = e.res;
         end
      end
   end

   // Issue one operation in the current (IDLE) cycle and wait for its done
   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input int lat,
                         input bit poke);
      exp_t e;
      op_sel = op; op1 = a; op2 = b; start = 1'b1;
      e.name = name; e.res = res; e.lat = lat; e.start_cyc = cyc;
      sb.push_back(e);
      #1;
      chk({name, "_stall_accept"}, {31'd0, stall}, 32'd1);
      chk({name, "_busy_accept"},  {31'd0, busy},  32'd0);
      @(posedge clk); #1;
      start = 1'b0; op_sel = 5'd0; op1 = 32'd0; op2 = 32'd0;
      for (int i = 0; i < 60; i++) begin
         if (sb.size() == 0) break;
         if (done !== 1'b1) begin
            chk({name, "_busy"},   {31'd0, busy},  32'd1);
            chk({name, "_stall"},  {31'd0, stall}, 32'd1);
            chk({name, "_hold"},   result, last_res);
         end
         // Second request while busy must be dropped
         if (poke && i == 3) begin
            start = 1'b1; op_sel = 5'b01010; op1 = 32'd5; op2 = 32'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
         sb.delete();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op_sel = 5'd0; op1 = 32'd0; op2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",   {31'd0, busy},  32'd0);
      chk("reset_done",   {31'd0, done},  32'd0);
      chk("reset_stall",  {31'd0, stall}, 32'd0);
      chk("reset_result", result,         32'd0);
      rst = 1'b0;

      run_op("mul_neg",   5'b01010, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFA, 2,  1'b0);
      run_op("mulh",      5'b01011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2,  1'b0);
      run_op("mulhsu",    5'b01100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  1'b0);
      run_op("mulhu",     5'b01101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2,  1'b0);
      run_op("mul_small", 5'b01010, 32'd7,         32'd6,         32'd42,        2,  1'b0);
      run_op("div_m7_2",  5'b01110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
      run_op("rem_m7_2",  5'b10000, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
      run_op("div_7_m2",  5'b01110, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
      run_op("rem_7_m2",  5'b10000, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 1'b0);
      run_op("divu_100_7",5'b01111, 32'd100,       32'd7,         32'd14,        33, 1'b1);
      run_op("remu_100_7",5'b10001, 32'd100,       32'd7,         32'd2,         33, 1'b0);
      run_op("divu_by0",  5'b01111, 32'd100,       32'd0,         32'hFFFF_FFFF, 2,  1'b0);
      run_op("remu_by0",  5'b10001, 32'd100,       32'd0,         32'd100,       2,  1'b0);
      run_op("div_ovf",   5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  1'b0);
      run_op("rem_ovf",   5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  1'b0);
      run_op("div_tail",  5'b01110, 32'd1000,      32'd10,        32'd100,       33, 1'b0);

      // Out-of-range opcodes in IDLE are ignored
      for (int k = 0; k < 3; k++) begin
         op_sel = (k == 0) ? 5'b00000 : ((k == 1) ? 5'b01001 : 5'b10010);
         op1 = 32'd9; op2 = 32'd3; start = 1'b1;
         #1;
         chk("badop_stall", {31'd0, stall}, 32'd0);
         @(posedge clk); #1;
         start = 1'b0;
         chk("badop_busy", {31'd0, busy}, 32'd0);
         @(posedge clk); #1;
         chk("badop_done", {31'd0, done}, 32'd0);
      end

      // Reset at division iteration 10 aborts without a done pulse
      op_sel = 5'b01110; op1 = 32'hFFFF_FFF9; op2 = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_res = 32'd0;
      chk("abort_busy",   {31'd0, busy},  32'd0);
      chk("abort_stall",  {31'd0, stall}, 32'd0);
      chk("abort_result", result,         32'd0);
      for (int k = 0; k < 40; k++) begin
         chk("abort_no_done", {31'd0, done}, 32'd0);
         @(posedge clk); #1;
      end

      run_op("mul_after_rst", 5'b01010, 32'd3, 32'd4, 32'd12, 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and result width. Only 32 is supported.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1: request a multiply/divide operation this cycle.
REQ-005 SHALL have port op_sel  input  5: operation code.
- 01010 MUL, 01011 MULH, 01100 MULHSU, 01101 MULHU.
- 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU.
REQ-006 SHALL have port op1  input  DATA_WIDTH: rs1 operand (multiplicand / dividend).
REQ-007 SHALL have port op2  input  DATA_WIDTH: rs2 operand (multiplier / divisor).
REQ-008 SHALL have port busy  output  1: operation in progress.
REQ-009 SHALL have port stall  output  1: hold the pipeline; combinational.
REQ-010 SHALL have port done  output  1: one-cycle pulse; result is valid in that cycle.
REQ-011 SHALL have port result  output  DATA_WIDTH: registered result.

Function
REQ-012 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-013 SHALL accept a request only in IDLE, with start=1 and op_sel in 01010..10001.
- On acceptance, op_sel, op1 and op2 are latched.
- A start with an out-of-range op_sel is ignored: no state change, done stays 0.
REQ-014 SHALL ignore start in MUL, DIV and DONE; no queuing.
REQ-015 SHALL drive busy=1 exactly in the MUL and DIV states.
REQ-016 SHALL drive stall = busy | (IDLE & start & op_sel in range). Stall covers the acceptance cycle, so the pipeline holds the instruction until done.
REQ-017 SHALL sequence multiply ops IDLE -> MUL -> DONE -> IDLE.
- The MUL state forms the 64-bit product.
- done is asserted 2 cycles after the acceptance edge.
REQ-018 SHALL select the multiply result as follows:
- MUL: product[31:0], signed x signed.
- MULH: product[63:32], signed x signed.
- MULHSU: product[63:32], op1 signed x op2 unsigned (op2 zero-extended to 33 bits).
- MULHU: product[63:32], unsigned x unsigned.
REQ-019 SHALL implement division as restoring radix-2: DIV state, 5-bit counter 0..31, one quotient bit per cycle.
- After the iteration with count=31: go to DONE.
- done is asserted 33 cycles after the acceptance edge.
REQ-020 SHALL perform signed DIV/REM on magnitudes, then correct signs.
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
REQ-021 SHALL handle divisor == 0 by going DIV -> DONE after 1 cycle (done 2 cycles after acceptance), with no iterations.
- DIV/DIVU result: 0xFFFFFFFF.
- REM/REMU result: op1.
REQ-022 SHALL handle signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM) by the 1-cycle path of REQ-021.
- DIV result: 0x80000000.
- REM result: 0.
REQ-023 SHALL hold done=1 for exactly one cycle (the DONE state), then return to IDLE.
REQ-024 SHALL keep result stable from the DONE cycle until the next DONE. It must not change during busy.
REQ-025 SHALL accept a new request in the IDLE cycle immediately after DONE, giving back-to-back operations with one idle cycle between them.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, enter IDLE and clear all of the following: counter, latched operands, result (0), busy (0), done (0).
REQ-027 SHALL abort any in-flight MUL/DIV on rst with no done pulse. start is ignored in any cycle where rst=1.

Verification
REQ-028 SHALL cover: MUL, op1=0xFFFFFFFE (-2), op2=3 -> done 2 cycles after accept; result=0xFFFFFFFA.
REQ-029 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-030 SHALL cover: DIV -7/2 -> 0xFFFFFFFD, done 33 cycles after accept; REM -7/2 -> 0xFFFFFFFF; busy and stall high throughout.
REQ-031 SHALL cover: DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, each done 2 cycles after accept.
REQ-032 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both on the 1-cycle path.
REQ-033 SHALL cover reset and edge cases:
- rst pulsed at DIV iteration 10 -> IDLE, busy=0, result=0, no done.
- start during busy -> ignored.
- op_sel=00000 in IDLE -> ignored, stall=0.
